pe_result_reader: RTL and testbench
===================================

Name: pe_result_reader

Overview:
- Consumer at the right-hand (output) end of the Booth PE array.
- After the controller applies a new Q vector / K matrix and pulses start, it waits a fixed compute latency and snapshots the packed per-row results.
- It then streams one row result per handshake on a valid/ready interface toward the softmax/accumulate path.
- It frees the array for the next operand set as soon as the snapshot is taken.

Parameters:
- MATRIX_SIZE, 3, number of PE rows; also the number of results per snapshot.
- OUTPUT_WIDTH, 9, signed width of one row result; matches the array's $clog2(MATRIX_SIZE*2**8)-1.
- LATENCY, 16, cycles from the start sample to a settled array output; legal range is at least 1.
- ROW_W, $clog2(MATRIX_SIZE) (minimum 1), width of the row index.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: new operands are on the array inputs this cycle.
- array_result  input  OUTPUT_WIDTH*MATRIX_SIZE  packed array output; row i is bits [(MATRIX_SIZE-i)*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH], so row 0 is in the MSBs.
- out_valid  output  1  out_data/out_row/out_last are valid.
- out_ready  input  1  downstream accepts the current word.
- out_data  output  OUTPUT_WIDTH  signed row result, unmodified two's complement.
- out_row  output  ROW_W  row index of out_data.
- out_last  output  1  high with the final row (MATRIX_SIZE-1).
- busy  output  1  high in WAIT and STREAM.
- snap  output  1  one-cycle pulse on the capture edge; the controller may change operands from the next cycle.
- done  output  1  one-cycle pulse the cycle after the last row handshake.
- start_drop  output  1  sticky flag: a start arrived while busy; cleared only by reset.

Behaviour:
- Reset (async, reset_n low): state IDLE, wait counter 0, row pointer 0, snapshot register 0. All outputs 0: out_valid, out_data, out_row, out_last, busy, snap, done, start_drop.
- FSM states are IDLE, WAIT, STREAM.
- IDLE:
  - start=1 → WAIT, counter loaded with LATENCY-1, busy=1 from the next cycle.
  - start=0 → stay in IDLE.
- WAIT:
  - Counter decrements every cycle.
  - On the edge where the counter equals 0: snapshot all MATRIX_SIZE slices of array_result, pulse snap for that cycle, row pointer ← 0, go to STREAM.
  - The capture edge is exactly LATENCY rising edges after the edge that sampled start.
- STREAM:
  - out_valid=1.
  - out_data = snapshot[row pointer] and out_row = row pointer, both driven from registers.
  - out_last = (row pointer == MATRIX_SIZE-1).
  - Handshake completes on a rising edge with out_valid & out_ready.
  - Non-last handshake: row pointer increments.
  - Last handshake: go to IDLE; out_valid=0 and done=1 in the next cycle; busy drops in that same cycle.
- Handshake stability: while out_valid=1 and out_ready=0, out_data, out_row and out_last are held stable. out_valid never drops without a handshake.
- Throughput: with out_ready tied high, one row per cycle, so a full read takes LATENCY + MATRIX_SIZE cycles.
- start while busy (WAIT or STREAM):
  - Ignored; no restart, no counter reload.
  - start_drop ← 1.
  - start in the same cycle as the done pulse is accepted, because the state is already IDLE.
- Snapshot isolation: array_result changes after snap have no effect on values being streamed.
- No arithmetic is performed; widths pass through and sign is preserved.
- MATRIX_SIZE=1: a single word with out_last=1; ROW_W=1 and out_row=0.
- LATENCY=1: capture on the first edge after the start sample.
- Reset asserted mid-WAIT or mid-STREAM: immediate return to the reset state; the partial stream is discarded and no done is produced.

Test Plan:
- Basic read (MATRIX_SIZE=3, OUTPUT_WIDTH=9, LATENCY=4): array_result={9'h005,9'h1FE,9'h0A0}, start at edge 0, out_ready=1 → snap at edge 4. Outputs, in order:
  - row0 = 0x005
  - row1 = 0x1FE (-2)
  - row2 = 0x0A0 with out_last=1
  - then done is high for one cycle and busy falls.
- Backpressure: same data, out_ready=0 for 5 cycles after out_valid rises → out_data holds 0x005 and out_row=0 throughout; once out_ready=1 the rows follow in order with no loss or duplicate.
- Snapshot isolation: after snap, array_result is changed to all-ones every cycle → streamed values remain 0x005, 0x1FE, 0x0A0.
- Start while busy: a second start at edge 2 → capture still occurs at edge 4, start_drop=1 and stays set; a start coinciding with the done cycle is accepted (busy=1 on the next cycle).
- Reset mid-stream: reset_n low after row1 is accepted → out_valid, busy and done are immediately 0 and no done pulse follows. A new start then yields row 0 first.
- Edge parameters: MATRIX_SIZE=1, LATENCY=1, array_result=9'h100 → snap one edge after start, a single word 0x100 with out_row=0 and out_last=1, then done.

Source files
------------

// File: rtl/pe_result_reader.sv
// Output-side reader for the Booth PE array: waits a fixed latency after start,
// snapshots every row result, then streams the rows over a valid/ready port.
module pe_result_reader #(
  parameter int MATRIX_SIZE  = 3,
  parameter int OUTPUT_WIDTH = 9,
  parameter int LATENCY      = 16,
  parameter int ROW_W        = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [OUTPUT_WIDTH*MATRIX_SIZE-1:0] array_result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUTPUT_WIDTH-1:0]             out_data,
  output logic [ROW_W-1:0]                    out_row,
  output logic                                out_last,
  output logic                                busy,
  output logic                                snap,
  output logic                                done,
  output logic                                start_drop
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    drop_q, drop_d;
  logic [OUTPUT_WIDTH-1:0] snap_mem_q [MATRIX_SIZE];
  logic [OUTPUT_WIDTH-1:0] snap_mem_d [MATRIX_SIZE];
  logic [ROW_W-1:0]        row_next;
  logic                    capture;

  assign capture  = (state_q == WAIT) && (cnt_q == '0);
  assign row_next = row_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    data_d     = data_q;
    last_d     = last_q;
    done_d     = 1'b0;
    drop_d     = drop_q | (start && (state_q != IDLE));
    snap_mem_d = snap_mem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (capture) begin
          // Row 0 sits in the MSBs of the packed array bus.
          for (int i = 0; i < MATRIX_SIZE; i++) begin
            snap_mem_d[i] = array_result[(MATRIX_SIZE-i)*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH];
          end
          state_d = STREAM;
          row_d   = '0;
          data_d  = array_result[MATRIX_SIZE*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH];
          last_d  = (MATRIX_SIZE == 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            row_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            row_d  = row_next;
            data_d = snap_mem_q[row_next];
            last_d = (row_next == ROW_W'(MATRIX_SIZE - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        snap_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      data_q     <= data_d;
      last_q     <= last_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      snap_mem_q <= snap_mem_d;
    end
  end

  assign out_valid  = (state_q == STREAM);
  assign out_data   = data_q;
  assign out_row    = row_q;
  assign out_last   = last_q;
  assign busy       = (state_q != IDLE);
  assign snap       = capture;
  assign done       = done_q;
  assign start_drop = drop_q;

endmodule

// File: tb/tb_pe_result_reader.sv
// Directed bench for pe_result_reader: a 3-row/latency-4 instance and a
// 1-row/latency-1 instance share clock and reset.
module tb_pe_result_reader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: MATRIX_SIZE=3, LATENCY=4
  logic        a_start = 1'b0, a_ready = 1'b0;
  logic [26:0] a_array = '0;
  logic        a_valid, a_last, a_busy, a_snap, a_done, a_drop;
  logic [8:0]  a_data;
  logic [1:0]  a_row;

  // Instance B: MATRIX_SIZE=1, LATENCY=1
  logic        b_start = 1'b0, b_ready = 1'b1;
  logic [8:0]  b_array = '0;
  logic        b_valid, b_last, b_busy, b_snap, b_done, b_drop;
  logic [8:0]  b_data;
  logic [0:0]  b_row;

  pe_result_reader #(.MATRIX_SIZE(3), .OUTPUT_WIDTH(9), .LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(a_start), .array_result(a_array),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_row(a_row),
    .out_last(a_last), .busy(a_busy), .snap(a_snap), .done(a_done),
    .start_drop(a_drop)
  );

  pe_result_reader #(.MATRIX_SIZE(1), .OUTPUT_WIDTH(9), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(b_start), .array_result(b_array),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_row(b_row),
    .out_last(b_last), .busy(b_busy), .snap(b_snap), .done(b_done),
    .start_drop(b_drop)
  );

  localparam logic [26:0] DATA = {9'h005, 9'h1FE, 9'h0A0};
  logic [8:0] exp_rows [3] = '{9'h005, 9'h1FE, 9'h0A0};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!a_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(a_valid), 32'd1);
  endtask

  // Expects row 0 on the port and out_ready high; ends in the done cycle.
  task automatic read_rows(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_valid"}, 32'(a_valid), 32'd1);
      chk({tag, "_data"}, 32'(a_data), 32'(exp_rows[i]));
      chk({tag, "_row"}, 32'(a_row), 32'(i));
      chk({tag, "_last"}, 32'(a_last), 32'(i == 2));
      $display("xfer %s row=%0d data=%h last=%0b", tag, a_row, a_data, a_last);
      tick();
    end
    chk({tag, "_done"}, 32'(a_done), 32'd1);
    chk({tag, "_busy_end"}, 32'(a_busy), 32'd0);
    chk({tag, "_valid_end"}, 32'(a_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_snap", 32'(a_snap), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_drop", 32'(a_drop), 32'd0);
    reset_n = 1'b1;
    tick();

    // Edge parameters: MATRIX_SIZE=1, LATENCY=1
    b_array = 9'h100;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_snap", 32'(b_snap), 32'd1);
    chk("b_busy", 32'(b_busy), 32'd1);
    chk("b_valid0", 32'(b_valid), 32'd0);
    tick();
    chk("b_valid", 32'(b_valid), 32'd1);
    chk("b_data", 32'(b_data), 32'h100);
    chk("b_row", 32'(b_row), 32'd0);
    chk("b_last", 32'(b_last), 32'd1);
    $display("xfer b row=%0d data=%h last=%0b", b_row, b_data, b_last);
    tick();
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_valid_end", 32'(b_valid), 32'd0);
    tick();
    chk("b_done_pulse", 32'(b_done), 32'd0);

    // Basic read
    a_array = DATA;
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t1_busy", 32'(a_busy), 32'd1);
    chk("t1_snap_early", 32'(a_snap), 32'd0);
    tick(); tick(); tick();
    chk("t1_snap", 32'(a_snap), 32'd1);
    chk("t1_valid_pre", 32'(a_valid), 32'd0);
    tick();
    chk("t1_snap_off", 32'(a_snap), 32'd0);
    read_rows("t1");
    tick();
    chk("t1_done_pulse", 32'(a_done), 32'd0);
    chk("t1_drop", 32'(a_drop), 32'd0);

    // Backpressure plus snapshot isolation
    a_ready = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_valid(20);
    for (int k = 0; k < 5; k++) begin
      a_array = '1;
      chk("t2_hold_data", 32'(a_data), 32'h005);
      chk("t2_hold_row", 32'(a_row), 32'd0);
      chk("t2_hold_valid", 32'(a_valid), 32'd1);
      tick();
    end
    a_ready = 1'b1;
    read_rows("t2");
    tick();

    // Start while busy, then start in the done cycle
    a_array = DATA;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t4_drop", 32'(a_drop), 32'd1);
    chk("t4_busy", 32'(a_busy), 32'd1);
    tick();
    chk("t4_snap", 32'(a_snap), 32'd1);
    tick();
    read_rows("t4a");
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("t4_restart_busy", 32'(a_busy), 32'd1);
    chk("t4_drop_sticky", 32'(a_drop), 32'd1);
    chk("t4_done_pulse", 32'(a_done), 32'd0);
    wait_valid(20);
    read_rows("t4b");
    tick();

    // Reset mid-stream
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_valid(20);
    tick();
    chk("t5_row1", 32'(a_row), 32'd1);
    tick();
    a_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t5_valid", 32'(a_valid), 32'd0);
    chk("t5_busy", 32'(a_busy), 32'd0);
    chk("t5_done", 32'(a_done), 32'd0);
    chk("t5_drop", 32'(a_drop), 32'd0);
    chk("t5_row", 32'(a_row), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_done", 32'(a_done), 32'd0);
    end
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_valid(20);
    read_rows("t5");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
